pipelined_csel_adder: RTL

- Parametrised, pipelined carry-select adder/subtractor. Next generation of the 8-bit carry-select adder.
- Splits a WIDTH-bit operation into NUM_BLK = WIDTH/BLOCK segments, with one segment per pipeline stage. Throughput is one op per cycle; latency is NUM_BLK cycles.
- Uses a valid/ready handshake on input and output, with full backpressure. Sits in the datapath library as the reusable wide adder for accumulators and ALUs.

---
 rtl/adder_pkg.sv | 17 +
 rtl/csel_block.sv | 25 ++
 rtl/pipelined_csel_adder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// adder_pkg: sizing helpers shared by the carry-select adder family.
// Revision: 1.0
// ============================================================================
package adder_pkg;

    function automatic int num_blk(input int width, input int block);
        return (block > 0) ? width / block : 1;
    endfunction

    function automatic bit geometry_ok(input int width, input int block);
        return (block >= 1) && (width >= block) && ((width % block) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/csel_block.sv
`default_nettype none
// ============================================================================
// csel_block: one carry-select segment, both carry hypotheses plus select mux.
// Revision: 1.0
// ============================================================================
module csel_block #(
    parameter int BLOCK = 8
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             cout
);

    logic [BLOCK:0] w_res0;
    logic [BLOCK:0] w_res1;

    assign w_res0 = {1'b0, a} + {1'b0, b};
    assign w_res1 = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, 1'b1};

    assign {cout, sum} = cin ? w_res1 : w_res0;

endmodule
`default_nettype wire

// File: rtl/pipelined_csel_adder.sv
`default_nettype none
// ============================================================================
// pipelined_csel_adder: WIDTH-bit add/sub, one carry-select segment per stage.
// Revision: 1.0
// ============================================================================
module pipelined_csel_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NUM_BLK = num_blk(WIDTH, BLOCK);
    localparam int LAST    = NUM_BLK - 1;

    generate
        if (!geometry_ok(WIDTH, BLOCK)) begin : g_bad_geometry
            $error("pipelined_csel_adder: WIDTH must be a positive multiple of BLOCK");
        end
    endgenerate

    logic [NUM_BLK-1:0] r_v;
    logic [NUM_BLK-1:0] r_c;
    logic [NUM_BLK-1:0] r_amsb;
    logic [NUM_BLK-1:0] r_bmsb;
    logic [WIDTH-1:0]   r_sum [NUM_BLK];
    logic [WIDTH-1:0]   r_a   [NUM_BLK];
    logic [WIDTH-1:0]   r_b   [NUM_BLK];

    logic [NUM_BLK-1:0] w_in_v;
    logic [NUM_BLK-1:0] w_in_c;
    logic [NUM_BLK-1:0] w_in_amsb;
    logic [NUM_BLK-1:0] w_in_bmsb;
    logic [WIDTH-1:0]   w_in_a   [NUM_BLK];
    logic [WIDTH-1:0]   w_in_b   [NUM_BLK];
    logic [WIDTH-1:0]   w_in_sum [NUM_BLK];

    logic [BLOCK-1:0]   w_blk_sum [NUM_BLK];
    logic [NUM_BLK-1:0] w_blk_c;
    logic [NUM_BLK-1:0] w_adv;
    logic [WIDTH-1:0]   w_b_eff;

    assign w_b_eff = sub ? ~b : b;

    // Operands travel pre-shifted so every stage consumes its low BLOCK bits.
    always_comb begin
        w_in_v[0]    = in_valid;
        w_in_c[0]    = sub | cin;
        w_in_a[0]    = a;
        w_in_b[0]    = w_b_eff;
        w_in_sum[0]  = '0;
        w_in_amsb[0] = a[WIDTH-1];
        w_in_bmsb[0] = w_b_eff[WIDTH-1];
        for (int k = 1; k < NUM_BLK; k++) begin
            w_in_v[k]    = r_v[k-1];
            w_in_c[k]    = r_c[k-1];
            w_in_a[k]    = r_a[k-1];
            w_in_b[k]    = r_b[k-1];
            w_in_sum[k]  = r_sum[k-1];
            w_in_amsb[k] = r_amsb[k-1];
            w_in_bmsb[k] = r_bmsb[k-1];
        end
    end

    // Unrolled form of adv[k] = !v[k] || adv[k+1]: a stage moves if any slot
    // at or downstream of it is empty, or the consumer is taking a result.
    always_comb begin
        for (int k = 0; k < NUM_BLK; k++) begin
            w_adv[k] = out_ready;
            for (int j = k; j < NUM_BLK; j++) begin
                if (!r_v[j]) begin
                    w_adv[k] = 1'b1;
                end
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_BLK; k++) begin : g_stage
            csel_block #(
                .BLOCK (BLOCK)
            ) u_csel (
                .a    (w_in_a[k][BLOCK-1:0]),
                .b    (w_in_b[k][BLOCK-1:0]),
                .cin  (w_in_c[k]),
                .sum  (w_blk_sum[k]),
                .cout (w_blk_c[k])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v    <= '0;
            r_c    <= '0;
            r_amsb <= '0;
            r_bmsb <= '0;
            for (int k = 0; k < NUM_BLK; k++) begin
                r_sum[k] <= '0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_BLK; k++) begin
                if (w_adv[k]) begin
                    r_v[k] <= w_in_v[k];
                    // Bubbles leave the data registers untouched.
                    if (w_in_v[k]) begin
                        r_sum[k]  <= w_in_sum[k] | (WIDTH'(w_blk_sum[k]) << (BLOCK * k));
                        r_c[k]    <= w_blk_c[k];
                        r_a[k]    <= w_in_a[k] >> BLOCK;
                        r_b[k]    <= w_in_b[k] >> BLOCK;
                        r_amsb[k] <= w_in_amsb[k];
                        r_bmsb[k] <= w_in_bmsb[k];
                    end
                end
            end
        end
    end

    assign in_ready  = w_adv[0];
    assign out_valid = r_v[LAST];
    assign sum       = r_sum[LAST];
    assign cout      = r_c[LAST];
    assign ovf       = (r_amsb[LAST] == r_bmsb[LAST]) && (r_sum[LAST][WIDTH-1] != r_amsb[LAST]);

endmodule
`default_nettype wire
